mem_boot_arbiter: RTL and testbench

- Owns the single port of the 256x8 program/data RAM and shares it between the RISC_SPM core and a host loader/debug port.
- While the host holds ownership, the core is kept in reset and the host reads or writes memory one byte at a time over a valid/ready handshake.
- On release, the core is held in reset for a programmable number of cycles, then runs from address 0 with full memory ownership.
- Sits between the core's memory bus, the RAM instance and the host/debug logic in the top level.

---
 rtl/mem_boot_arbiter_if.sv | 42 ++++
 rtl/mem_boot_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_boot_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_boot_arbiter_if.sv
// Host loader/debug port of mem_boot_arbiter.
// Carries the ownership request, the byte-wide valid/ready access
// handshake, the registered read-return and the grant indication.
// The "master" modport is the host side; "slave" is the arbiter side.
interface mem_boot_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              host_req;
    logic              host_valid;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ready;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    logic              grant_host;

    modport master (
        output host_req,
        output host_valid,
        output host_we,
        output host_addr,
        output host_wdata,
        input  host_ready,
        input  host_rdata,
        input  host_rvalid,
        input  grant_host
    );

    modport slave (
        input  host_req,
        input  host_valid,
        input  host_we,
        input  host_addr,
        input  host_wdata,
        output host_ready,
        output host_rdata,
        output host_rvalid,
        output grant_host
    );
endinterface

// File: rtl/mem_boot_arbiter.sv
// mem_boot_arbiter: owns the single port of the program/data RAM and
// shares it between the RISC_SPM core and a host loader/debug port.
//
// While the host owns memory the core is held in reset and the host
// performs one byte access per cycle (host_ready = host_valid). When the
// host lets go, the core stays in reset for RELEASE_CYCLES more cycles and
// then runs from address 0 with exclusive use of the RAM.
//
// Optional build macro BOOT_CHECKSUM_EN adds the boot_sum output: the
// modulo-2^DATA_W sum of host write data accepted since the host last
// took ownership.
module mem_boot_arbiter #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
`ifdef BOOT_CHECKSUM_EN
    output logic [DATA_W-1:0] boot_sum,
`endif
    mem_boot_arbiter_if.slave hbus,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    // The release counter only needs to hold 1..255.
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(RELEASE_CYCLES);

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        HOST       = 2'd2,
        RELEASE    = 2'd3
    } state_t;

    state_t            state_q,       state_d;
    logic [CNT_W-1:0]  rel_cnt_q,     rel_cnt_d;
    logic [DATA_W-1:0] host_rdata_q,  host_rdata_d;
    logic              host_rvalid_q, host_rvalid_d;

    // Decoded host access of the current cycle (only meaningful in HOST).
    logic host_acc;
    logic host_wr;
    logic host_rd;

    assign host_acc = (state_q == HOST) && hbus.host_valid;
    assign host_wr  = host_acc && hbus.host_we;
    assign host_rd  = host_acc && !hbus.host_we;

    // State, release counter and host read-return registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RESET_HOLD;
            rel_cnt_q     <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rel_cnt_q     <= rel_cnt_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    // Ownership sequencing: who owns the RAM next and the release countdown.
    always_comb begin
        state_d   = state_q;
        rel_cnt_d = rel_cnt_q;
        case (state_q)
            RESET_HOLD: begin
                if (hbus.host_req) begin
                    state_d = HOST;
                end else begin
                    state_d   = RELEASE;
                    rel_cnt_d = REL_LOAD;
                end
            end
            RUN: begin
                // The core's access in this cycle completes regardless.
                if (hbus.host_req) begin
                    state_d = HOST;
                end
            end
            HOST: begin
                if (!hbus.host_req) begin
                    state_d   = RELEASE;
                    rel_cnt_d = REL_LOAD;
                end
            end
            RELEASE: begin
                if (hbus.host_req) begin
                    // Host came back: abandon the countdown.
                    state_d   = HOST;
                    rel_cnt_d = '0;
                end else if (rel_cnt_q <= CNT_W'(1)) begin
                    // Last reset cycle for the core; it runs next cycle.
                    state_d   = RUN;
                    rel_cnt_d = '0;
                end else begin
                    rel_cnt_d = rel_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d   = RESET_HOLD;
                rel_cnt_d = '0;
            end
        endcase
    end

    // RAM port steering, core read-back and host read capture.
    always_comb begin
        mem_addr      = cpu_addr;
        mem_wdata     = cpu_wdata;
        mem_we        = 1'b0;
        cpu_rdata     = '0;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = 1'b0;
        case (state_q)
            RUN: begin
                mem_we    = cpu_we;
                cpu_rdata = mem_rdata;
            end
            HOST: begin
                // cpu_we is ignored; the core is in reset.
                mem_addr  = hbus.host_addr;
                mem_wdata = hbus.host_wdata;
                mem_we    = host_wr;
                if (host_rd) begin
                    host_rdata_d  = mem_rdata;
                    host_rvalid_d = 1'b1;
                end
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    assign cpu_rst          = (state_q == RUN);
    assign hbus.grant_host  = (state_q == HOST);
    assign hbus.host_ready  = host_acc;
    assign hbus.host_rdata  = host_rdata_q;
    assign hbus.host_rvalid = host_rvalid_q;

`ifdef BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] boot_sum_q, boot_sum_d;

    // Running checksum of accepted host write data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            boot_sum_q <= '0;
        end else begin
            boot_sum_q <= boot_sum_d;
        end
    end

    // Clear on each entry into HOST, accumulate host writes, else hold.
    always_comb begin
        boot_sum_d = boot_sum_q;
        if ((state_d == HOST) && (state_q != HOST)) begin
            boot_sum_d = '0;
        end else if (host_wr) begin
            boot_sum_d = boot_sum_q + hbus.host_wdata;
        end
    end

    assign boot_sum = boot_sum_q;
`else
    // Checksum build option disabled: no boot_sum port or accumulator.
`endif

endmodule

// File: tb/tb_mem_boot_arbiter.sv
// Directed bench for mem_boot_arbiter with a behavioural 256x8 RAM and a
// read-return scoreboard.
module tb_mem_boot_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int REL    = 4;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rst;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
`ifdef BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] boot_sum;
`endif

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] ram [256];

    mem_boot_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) hif ();

    mem_boot_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RELEASE_CYCLES(REL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef BOOT_CHECKSUM_EN
        .boot_sum  (boot_sum),
`endif
        .hbus      (hif),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rdata (cpu_rdata),
        .cpu_rst   (cpu_rst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = ram[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every read return is matched against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (host_rvalid_seen()) begin
                if (exp_q.size() == 0) begin
                    check("rvalid_unexpected", hif.host_rvalid, 0);
                end else begin
                    check("rdata_sb", hif.host_rdata, exp_q.pop_front());
                end
            end
        end
    end

    function automatic bit host_rvalid_seen();
        return hif.host_rvalid === 1'b1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        hif.host_valid = 1'b1;
        hif.host_we    = 1'b1;
        hif.host_addr  = a;
        hif.host_wdata = d;
        #1;
        check("wr_ready", hif.host_ready, 1);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, a);
        check("wr_mem_wdata", mem_wdata, d);
        check("wr_cpu_rst", cpu_rst, 0);
    endtask

    task automatic host_read(input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        hif.host_valid = 1'b1;
        hif.host_we    = 1'b0;
        hif.host_addr  = a;
        exp_q.push_back(exp);
        #1;
        check("rd_ready", hif.host_ready, 1);
        check("rd_mem_we", mem_we, 0);
        @(negedge clk);
        hif.host_valid = 1'b0;
        #1;
        check("rd_rvalid_lat", hif.host_rvalid, 1);
        @(negedge clk);
        #1;
        check("rd_rvalid_pulse", hif.host_rvalid, 0);
    endtask

    task automatic idle();
        @(negedge clk);
        hif.host_valid = 1'b0;
        hif.host_we    = 1'b0;
    endtask

    // Core must see exactly REL cycles of reset, then run.
    task automatic expect_release_window(input string tag);
        for (int i = 0; i < REL; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, cpu_rst, 0);
            check({tag, "_nogrant"}, hif.grant_host, 0);
        end
        @(negedge clk);
        check({tag, "_run"}, cpu_rst, 1);
    endtask

    initial begin
        rst            = 1'b1;
        hif.host_req   = 1'b1;
        hif.host_valid = 1'b1;
        hif.host_we    = 1'b1;
        hif.host_addr  = '0;
        hif.host_wdata = '0;
        cpu_addr       = '0;
        cpu_wdata      = '0;
        cpu_we         = 1'b0;

        // Reset state, with host activity presented that must be ignored.
        @(negedge clk);
        #1;
        check("rst_cpu_rst", cpu_rst, 0);
        check("rst_grant", hif.grant_host, 0);
        check("rst_ready", hif.host_ready, 0);
        check("rst_rvalid", hif.host_rvalid, 0);
        check("rst_rdata", hif.host_rdata, 0);
        check("rst_mem_we", mem_we, 0);
`ifdef BOOT_CHECKSUM_EN
        check("rst_sum", boot_sum, 0);
`endif

        // Power-up release with no host request.
        @(negedge clk);
        hif.host_req   = 1'b0;
        hif.host_valid = 1'b0;
        hif.host_we    = 1'b0;
        rst            = 1'b0;
        expect_release_window("boot");

        // RUN: RAM port follows the core; host access ignored.
        cpu_addr  = 8'h55;
        cpu_wdata = 8'hA5;
        cpu_we    = 1'b1;
        hif.host_valid = 1'b1;
        #1;
        check("run_mem_addr", mem_addr, 8'h55);
        check("run_mem_we", mem_we, 1);
        check("run_mem_wdata", mem_wdata, 8'hA5);
        check("run_host_ignored", hif.host_ready, 0);
        @(negedge clk);
        cpu_we = 1'b0;
        hif.host_valid = 1'b0;
        #1;
        check("run_cpu_rdata", cpu_rdata, 8'hA5);
        check("run_no_rvalid", hif.host_rvalid, 0);

        // Host takes ownership and loads bytes.
        @(negedge clk);
        hif.host_req = 1'b1;
        @(negedge clk);
        cpu_we = 1'b1;
        #1;
        check("host_grant", hif.grant_host, 1);
        check("host_cpu_rst", cpu_rst, 0);
        check("host_cpu_we_ignored", mem_we, 0);
        check("host_cpu_rdata", cpu_rdata, 0);
        host_write(8'd130, 8'h01);
        host_write(8'd131, 8'h01);
        host_write(8'd0, 8'h00);
        idle();
        cpu_we = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        #1;
        check("host_sum", boot_sum, 8'h02);
`endif
        host_read(8'd130, 8'h01);

        // Full release back to the core.
        @(negedge clk);
        hif.host_req = 1'b0;
        expect_release_window("rel1");
`ifdef BOOT_CHECKSUM_EN
        check("run_sum_held", boot_sum, 8'h02);
`endif

        // Core write in the same cycle the host requests ownership.
        cpu_addr  = 8'd130;
        cpu_wdata = 8'h02;
        cpu_we    = 1'b1;
        hif.host_req = 1'b1;
        #1;
        check("race_mem_we", mem_we, 1);
        check("race_mem_addr", mem_addr, 8'd130);
        check("race_mem_wdata", mem_wdata, 8'h02);
        check("race_grant_pre", hif.grant_host, 0);
        @(negedge clk);
        cpu_we = 1'b0;
        #1;
        check("race_grant", hif.grant_host, 1);
        check("race_cpu_rst", cpu_rst, 0);
`ifdef BOOT_CHECKSUM_EN
        check("reentry_sum_clr", boot_sum, 0);
`endif
        host_read(8'd130, 8'h02);

        // Release abandoned two cycles in; core never leaves reset.
        @(negedge clk);
        hif.host_req = 1'b0;
        @(negedge clk);
        check("abort_hold1", cpu_rst, 0);
        @(negedge clk);
        check("abort_hold2", cpu_rst, 0);
        check("abort_nogrant", hif.grant_host, 0);
        hif.host_req = 1'b1;
        @(negedge clk);
        check("abort_regrant", hif.grant_host, 1);
        check("abort_cpu_rst", cpu_rst, 0);
        @(negedge clk);
        hif.host_req = 1'b0;
        expect_release_window("rel2");

        // Reset during a host read drops the pending read return.
        @(negedge clk);
        hif.host_req = 1'b1;
        @(negedge clk);
        hif.host_valid = 1'b1;
        hif.host_we    = 1'b0;
        hif.host_addr  = 8'd131;
        @(posedge clk);
        #1;
        check("midrd_rvalid_pending", hif.host_rvalid, 1);
        rst = 1'b1;
        #1;
        check("midrd_rvalid", hif.host_rvalid, 0);
        check("midrd_rdata", hif.host_rdata, 0);
        check("midrd_cpu_rst", cpu_rst, 0);
        check("midrd_grant", hif.grant_host, 0);
        check("midrd_ready", hif.host_ready, 0);
        @(negedge clk);
        hif.host_valid = 1'b0;
        hif.host_req   = 1'b0;
        check("midrd_rvalid_later", hif.host_rvalid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
